// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and fixed-latency access sequencer for the shared data memory.
// The CPU MEM stage and the debug/loader port are serialised; the CPU is stalled until its access is in DONE.
module dmem_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic [31:0]       dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int               LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              grant_dbg;
    logic              final_cycle;

    // On a tie the requester that did not win last time is served.
    assign grant_dbg   = dbg_req_i && (!cpu_req_i || (last_q == OWN_CPU));
    assign final_cycle = (state_q == S_ACCESS) && (lat_q == LAT_LAST);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    owner_d = grant_dbg;
                    last_d  = grant_dbg;
                    we_d    = grant_dbg ? dbg_we_i : cpu_we_i;
                    addr_d  = (grant_dbg ? dbg_addr_i : cpu_addr_i) & WORD_MASK;
                    wdata_d = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
                    lat_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (final_cycle) begin
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata_i;
                        else                    cpu_rdata_d = mem_rdata_i;
                    end
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (cpu_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stall is masked during reset so every output reads zero while rst_i is high.
    assign cpu_stall_o = cpu_req_i && !rst_i && !((state_q == S_DONE) && (owner_q == OWN_CPU));
    assign dbg_ack_o   = (state_q == S_DONE) && (owner_q == OWN_DBG);
    assign mem_en_o    = (state_q == S_ACCESS);
    assign mem_we_o    = final_cycle && we_q;
    assign mem_addr_o  = mem_en_o ? addr_q : '0;
    assign mem_wdata_o = mem_en_o ? wdata_q : '0;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
